// File: rtl/mux2_rr_arbiter.sv
// Two-requester burst arbiter with round-robin priority, feeding one shared channel.
// A grant is held for a whole burst; an abandoned burst is released after TIMEOUT idle cycles.
module mux2_rr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             last0,
  input  logic             last1,
  output logic             ack0,
  output logic             ack1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;

  logic own_req;
  logic last_accepted;
  logic idle_expire;

  // Grant choice shared by IDLE and the end-of-burst handover.
  function automatic state_e pick(input logic r0, input logic r1, input logic p);
    if (r0 && r1) return p ? GNT1 : GNT0;
    if (r0)       return GNT0;
    if (r1)       return GNT1;
    return IDLE;
  endfunction

  // Outputs are pure decodes of state plus the current-cycle inputs.
  always_comb begin
    sel           = (state_q == GNT1);
    busy          = (state_q != IDLE);
    own_req       = sel ? req1 : req0;
    out_valid     = busy & own_req;
    out_data      = sel ? data1 : data0;
    out_last      = sel ? last1 : last0;
    ack0          = (state_q == GNT0) & req0 & out_ready;
    ack1          = (state_q == GNT1) & req1 & out_ready;
    last_accepted = (ack0 | ack1) & out_last;
    idle_expire   = busy & ~own_req & (idle_cnt_q == IDLE_LIMIT);
    timeout_err   = idle_expire;
  end

  // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d    = pick(req0, req1, prio_q);
        idle_cnt_d = '0;
      end
      GNT0, GNT1: begin
        if (last_accepted) begin
          // The finishing requester may only re-win when the other one is not asking.
          prio_d     = ~sel;
          state_d    = sel ? pick(req0, req1 & ~req0, ~sel)
                           : pick(req0 & ~req1, req1, ~sel);
          idle_cnt_d = '0;
        end else if (!own_req) begin
          if (idle_expire) begin
            state_d    = IDLE;
            prio_d     = ~sel;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        idle_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against an owner/priority/idle-count model of the arbitration rules.
module tb_mux2_rr_arbiter;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic             last0 = 1'b0, last1 = 1'b0;
  logic             out_ready = 1'b0;
  logic             ack0, ack1, out_valid, out_last, sel, busy, timeout_err;
  logic [WIDTH-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  // Model: owner -1 = nobody, else the requester holding the grant.
  int m_owner = -1;
  int m_prio  = 0;
  int m_idle  = 0;

  logic obs_sel, obs_ack0, obs_ack1, obs_valid, obs_tmo;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .data0(data0), .data1(data1),
    .last0(last0), .last1(last1),
    .ack0(ack0), .ack1(ack1),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready),
    .sel(sel), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic r0, input logic r1, input int p);
    if (r0 && r1) return p;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_check();
    logic r [2];
    logic l [2];
    logic e_own_req, e_sel, e_busy, e_valid, e_ack0, e_ack1, e_last, e_tmo;
    logic [WIDTH-1:0] e_data;
    int i, o;
    r[0] = req0; r[1] = req1;
    l[0] = last0; l[1] = last1;
    e_sel     = (m_owner == 1);
    e_busy    = (m_owner >= 0);
    e_own_req = e_busy ? r[m_owner] : 1'b0;
    e_valid   = e_own_req;
    e_ack0    = (m_owner == 0) && req0 && out_ready;
    e_ack1    = (m_owner == 1) && req1 && out_ready;
    e_data    = e_sel ? data1 : data0;
    e_last    = e_sel ? last1 : last0;
    e_tmo     = e_busy && !e_own_req && (m_idle + 1 == TIMEOUT);

    check("sel", 32'(sel), 32'(e_sel));
    check("busy", 32'(busy), 32'(e_busy));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("ack0", 32'(ack0), 32'(e_ack0));
    check("ack1", 32'(ack1), 32'(e_ack1));
    check("out_data", 32'(out_data), 32'(e_data));
    check("out_last", 32'(out_last), 32'(e_last));
    check("timeout_err", 32'(timeout_err), 32'(e_tmo));
    obs_sel = sel; obs_ack0 = ack0; obs_ack1 = ack1; obs_valid = out_valid; obs_tmo = timeout_err;

    if (m_owner < 0) begin
      m_owner = pick(req0, req1, m_prio);
    end else begin
      i = m_owner;
      o = 1 - i;
      if ((i == 0 ? e_ack0 : e_ack1) && l[i]) begin
        m_prio = o;
        if (r[o]) r[i] = 1'b0;
        m_owner = pick(r[0], r[1], m_prio);
        m_idle  = 0;
      end else if (!r[i]) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_owner = -1;
          m_prio  = o;
          m_idle  = 0;
        end
      end else begin
        m_idle = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare on the falling edge.
  task automatic cycle(input logic r0, input logic r1, input logic l0, input logic l1,
                       input logic rdy);
    req0 = r0; req1 = r1; last0 = l0; last1 = l1; out_ready = rdy;
    data0 = WIDTH'($urandom);
    data1 = WIDTH'($urandom);
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ack", 32'({ack0, ack1}), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    m_owner = -1; m_prio = 0; m_idle = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n_ack0, n_ack1, tmo_at;
    int hold0, hold1;
    logic r0, r1;

    @(posedge clk);
    #1;
    do_reset();

    // Both request together, one-beat bursts: grants alternate 0,1,0,1 without bubbles.
    cycle(1, 1, 1, 1, 1);
    check("alt_idle_valid", 32'(obs_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, 1, 1, 1);
      check("alt_sel", 32'(obs_sel), 32'(k % 2));
      check("alt_ack", 32'({obs_ack1, obs_ack0}), (k % 2) ? 32'd2 : 32'd1);
    end
    cycle(0, 0, 0, 0, 1);

    // Four-beat burst from requester 0 with requester 1 waiting from beat 2.
    do_reset();
    n_ack0 = 0; n_ack1 = 0;
    cycle(1, 0, 0, 0, 1);
    for (int b = 1; b <= 4; b++) begin
      cycle(1, b >= 2, b == 4, 0, 1);
      n_ack0 += int'(obs_ack0);
      n_ack1 += int'(obs_ack1);
    end
    check("burst_ack0", 32'(n_ack0), 32'd4);
    check("burst_ack1", 32'(n_ack1), 32'd0);
    cycle(0, 1, 0, 0, 0);
    check("burst_handover_sel", 32'(obs_sel), 32'd1);

    // Stall in GNT1: valid held, no ack, no timeout.
    for (int s = 0; s < 3; s++) begin
      cycle(0, 1, 0, 0, 0);
      check("stall_valid", 32'(obs_valid), 32'd1);
      check("stall_ack1", 32'(obs_ack1), 32'd0);
      check("stall_tmo", 32'(obs_tmo), 32'd0);
    end
    cycle(0, 1, 0, 1, 1);

    // Requester 0 abandons its burst while requester 1 waits.
    do_reset();
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    tmo_at = 0;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      cycle(0, 1, 0, 0, 1);
      if (obs_tmo && tmo_at == 0) tmo_at = c;
    end
    check("tmo_cycle", 32'(tmo_at), 32'(TIMEOUT));
    cycle(0, 1, 0, 1, 1);
    check("tmo_then_gnt1", 32'({obs_sel, obs_ack1}), 32'd3);

    // Reset in the middle of a GNT1 burst, then both requesting gets GNT0.
    cycle(0, 1, 0, 0, 1);
    do_reset();
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 0, 1);
    check("post_rst_gnt0", 32'({obs_sel, obs_ack0}), 32'd1);

    // Requester 1 alone, back-to-back two-beat bursts with no dead cycles.
    do_reset();
    cycle(0, 1, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 0, k % 2, 1);
      check("b2b_ack1", 32'(obs_ack1), 32'd1);
    end

    // Randomized traffic, including long idle stretches that force timeouts.
    hold0 = 0; hold1 = 0;
    for (int t = 0; t < 3000; t++) begin
      if (hold0 == 0 && $urandom_range(39, 0) == 0) hold0 = $urandom_range(25, 5);
      if (hold1 == 0 && $urandom_range(39, 0) == 0) hold1 = $urandom_range(25, 5);
      r0 = (hold0 > 0) ? 1'b0 : ($urandom_range(7, 0) != 0);
      r1 = (hold1 > 0) ? 1'b0 : ($urandom_range(7, 0) != 0);
      if (hold0 > 0) hold0--;
      if (hold1 > 0) hold1--;
      if (t == 1500) do_reset();
      cycle(r0, r1, $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
            $urandom_range(3, 0) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each channel.
REQ-002 Parameter: TIMEOUT, default 15, idle cycles tolerated mid-burst before a forced release (1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0, req1  input  1 each  requester valid; requester i presents a beat while reqi=1.
REQ-006 data0, data1  input  WIDTH each  requester beat data.
REQ-007 last0, last1  input  1 each  marks the final beat of requester i's burst.
REQ-008 ack0, ack1  output  1 each  beat accepted from requester i this cycle.
REQ-009 out_valid  output  1  shared channel carries a valid beat.
REQ-010 out_data  output  WIDTH  shared channel data.
REQ-011 out_last  output  1  shared channel last-beat flag.
REQ-012 out_ready  input  1  downstream accepts the beat when out_valid=1.
REQ-013 sel  output  1  current mux select: 0 = requester 0, 1 = requester 1.
REQ-014 busy  output  1  a grant is held (state GNT0 or GNT1).
REQ-015 timeout_err  output  1  one-cycle pulse on a forced release.

Function
REQ-016 FSM states: IDLE, GNT0, GNT1, registered; sel=1 only in GNT1, sel=0 in all other states.
REQ-017 Datapath: a 2-to-1 selection; out_data/out_last = data1/last1 when sel=1, else data0/last0, combinational from the inputs.
REQ-018 out_valid = (state==GNT0 & req0) | (state==GNT1 & req1); out_valid=0 in IDLE.
REQ-019 acki = (state==GNTi) & reqi & out_ready; a beat transfers exactly when acki=1.
REQ-020 Priority pointer prio (1 bit): requester favoured when both request simultaneously.
REQ-021 IDLE: only req0 -> GNT0; only req1 -> GNT1; both -> GNT(prio); neither -> stay in IDLE.
REQ-022 Grant latency: one cycle from a request seen in IDLE to out_valid.
REQ-023 In GNTi, hold the grant until a beat with lasti=1 is accepted; no pre-emption by the other requester.
REQ-024 On acceptance of the last beat from requester i: prio <= ~i; the next state is chosen by the REQ-021 rule, using the updated priority, from the current-cycle req0/req1, excluding reqi unless the other requester is idle; no bubble cycle.
REQ-025 In GNTi with reqi=0, stay in GNTi and increment the 8-bit idle counter; clear the counter on any cycle with reqi=1 and on any state change.
REQ-026 When the idle counter reaches TIMEOUT, go to IDLE, set prio <= ~i and pulse timeout_err for one cycle.
REQ-027 out_ready=0 while out_valid=1 stalls the channel with no state change; the idle counter does not increment (reqi=1).
REQ-028 Requester i asserting reqi with lasti=1 on its first beat is a legal one-beat burst.

Reset
REQ-029 rst_n=0 immediately forces: state=IDLE, prio=0, idle counter=0, sel=0, busy=0, timeout_err=0, out_valid=0, ack0=ack1=0.
REQ-030 Reset asserted mid-burst abandons the burst; after release, arbitration restarts from IDLE with prio=0.
REQ-031 Reset release is synchronous to clk; the first grant is possible on the first clk edge after release.

Verification
REQ-032 Both req0/req1 rise together after reset, 1-beat bursts, out_ready=1 -> GNT0 first (sel=0, out_data=data0); then GNT1 with no bubble cycle; the grants alternate 0,1,0,1.
REQ-033 req0 holds a 4-beat burst while req1 is asserted from beat 2 -> four ack0 pulses, then sel=1 on the cycle after the last ack0; no ack1 before that.
REQ-034 In GNT1, out_ready=0 for 3 cycles with req1=1 -> out_valid=1, ack1=0, data stable, no timeout_err.
REQ-035 TIMEOUT=15, req0 drops mid-burst -> timeout_err pulses on the 15th idle cycle; state=IDLE next; a pending req1 is granted next.
REQ-036 rst_n pulsed low mid-burst in GNT1 -> sel=0, busy=0, out_valid=0 immediately; after release, both requesting -> GNT0 is granted.
REQ-037 Only req1 is active for repeated bursts -> back-to-back GNT1 grants, with no dead cycles between bursts.
